// File: rtl/mine_controller_if.sv
// Signal bundle between the minesweeper game controller and its surroundings (buttons + board).
// The slave modport is the controller's view; master is the button/board side.
interface mine_controller_if #(
  parameter int GRID_SIZE  = 3,
  parameter int STATE_SIZE = 4,
  parameter int COUNT_W    = 8
);
  localparam int N = GRID_SIZE * GRID_SIZE;

  logic                    btnNew;
  logic                    btnReveal;
  logic                    btnMove;
  logic [1:0]              btnDir;
  logic [N-1:0]            bombSeed;
  logic [STATE_SIZE*N-1:0] states;
  logic [N-1:0]            nextCursorGrid;

  logic [N-1:0]            bombGrid;
  logic [N-1:0]            revealGrid;
  logic [N-1:0]            cursorGrid;
  logic                    move;
  logic [1:0]              dir;
  logic [1:0]              gameState;
  logic                    busy;
  logic [COUNT_W-1:0]      revealCount;

  modport slave (
    input  btnNew, btnReveal, btnMove, btnDir, bombSeed, states, nextCursorGrid,
    output bombGrid, revealGrid, cursorGrid, move, dir, gameState, busy, revealCount
  );

  modport master (
    output btnNew, btnReveal, btnMove, btnDir, bombSeed, states, nextCursorGrid,
    input  bombGrid, revealGrid, cursorGrid, move, dir, gameState, busy, revealCount
  );
endinterface

// File: rtl/mine_controller.sv
// Minesweeper game controller: turns button pulses into cursor moves and reveals,
// runs the multi-cycle zero-cell flood fill against the board's cell states and tracks win/lose.
module mine_controller #(
  parameter int GRID_SIZE  = 3,
  parameter int STATE_SIZE = 4,
  parameter int COUNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  mine_controller_if.slave bus
);
  localparam int N = GRID_SIZE * GRID_SIZE;
  localparam logic [N-1:0] CURSOR_HOME = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_MOVE,
    S_FLOOD,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  // In-grid 8-neighbour mask of cell k; rows never wrap into each other.
  function automatic logic [N-1:0] nbr_mask(input int k);
    logic [N-1:0] m;
    int r, c, rr, cc;
    m = '0;
    r = k / GRID_SIZE;
    c = k % GRID_SIZE;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        if ((dr != 0 || dc != 0) && rr >= 0 && rr < GRID_SIZE && cc >= 0 && cc < GRID_SIZE)
          m[rr*GRID_SIZE + cc] = 1'b1;
      end
    end
    return m;
  endfunction

  state_t                r_state;
  logic [N-1:0]          r_bomb_grid;
  logic [N-1:0]          r_reveal_grid;
  logic [N-1:0]          r_cursor_grid;
  logic                  r_move;
  logic [1:0]            r_dir;

  state_t                w_state_next;
  logic [N-1:0]          w_bomb_next;
  logic [N-1:0]          w_reveal_next;
  logic [N-1:0]          w_cursor_next;
  logic [1:0]            w_dir_next;

  logic [N-1:0]          w_zero;
  logic [N-1:0]          w_expand;
  logic [STATE_SIZE-1:0] w_cur_state;
  logic                  w_cur_bomb;
  logic                  w_cur_revealed;
  logic [1:0]            w_game_state;

  // A cell joins the next flood ring when any revealed zero-count neighbour touches it.
  for (genvar k = 0; k < N; k++) begin : g_cell
    localparam logic [N-1:0] NBR = nbr_mask(k);
    assign w_zero[k]   = r_reveal_grid[k] & (bus.states[k*STATE_SIZE +: STATE_SIZE] == '0);
    assign w_expand[k] = ~r_bomb_grid[k] & ~r_reveal_grid[k] & (|(NBR & w_zero));
  end

  always_comb begin
    w_cur_state = '0;
    for (int k = 0; k < N; k++) begin
      if (r_cursor_grid[k]) w_cur_state = w_cur_state | bus.states[k*STATE_SIZE +: STATE_SIZE];
    end
  end

  assign w_cur_bomb     = |(r_cursor_grid & r_bomb_grid);
  assign w_cur_revealed = |(r_cursor_grid & r_reveal_grid);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    w_state_next  = r_state;
    w_bomb_next   = r_bomb_grid;
    w_reveal_next = r_reveal_grid;
    w_cursor_next = r_cursor_grid;
    w_dir_next    = r_dir;

    if (bus.btnNew) begin
      w_bomb_next   = bus.bombSeed;
      w_reveal_next = '0;
      w_cursor_next = CURSOR_HOME;
      w_state_next  = S_CHECK;
    end else begin
      case (r_state)
        S_PLAY: begin
          if (bus.btnReveal) begin
            if (!w_cur_revealed) begin
              if (w_cur_bomb) begin
                w_reveal_next = r_reveal_grid | r_bomb_grid;
                w_state_next  = S_LOSE;
              end else begin
                w_reveal_next = r_reveal_grid | r_cursor_grid;
                w_state_next  = (w_cur_state == '0) ? S_FLOOD : S_CHECK;
              end
            end
          end else if (bus.btnMove) begin
            w_dir_next   = bus.btnDir;
            w_state_next = S_MOVE;
          end
        end
        // An all-zero proposal means the move would leave the grid.
        S_MOVE: begin
          if (|bus.nextCursorGrid) w_cursor_next = bus.nextCursorGrid;
          w_state_next = S_PLAY;
        end
        S_FLOOD: begin
          if (|w_expand) w_reveal_next = r_reveal_grid | w_expand;
          else           w_state_next  = S_CHECK;
        end
        S_CHECK: begin
          w_state_next = (&(r_reveal_grid | r_bomb_grid)) ? S_WIN : S_PLAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_bomb_grid   <= '0;
      r_reveal_grid <= '0;
      r_cursor_grid <= CURSOR_HOME;
      r_move        <= 1'b0;
      r_dir         <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      r_state       <= w_state_next;
      r_bomb_grid   <= w_bomb_next;
      r_reveal_grid <= w_reveal_next;
      r_cursor_grid <= w_cursor_next;
      r_move        <= (w_state_next == S_MOVE);
      r_dir         <= w_dir_next;
    end
  end

  always_comb begin
    case (r_state)
      S_IDLE:  w_game_state = 2'b00;
      S_WIN:   w_game_state = 2'b10;
      S_LOSE:  w_game_state = 2'b11;
      default: w_game_state = 2'b01;
    endcase
  end

  assign bus.bombGrid    = r_bomb_grid;
  assign bus.revealGrid  = r_reveal_grid;
  assign bus.cursorGrid  = r_cursor_grid;
  assign bus.move        = r_move;
  assign bus.dir         = r_dir;
  assign bus.gameState   = w_game_state;
  assign bus.busy        = (r_state == S_MOVE) || (r_state == S_FLOOD) || (r_state == S_CHECK);
  assign bus.revealCount = COUNT_W'($countones(r_reveal_grid));
endmodule

// File: tb/tb_mine_controller.sv
// Directed bench for mine_controller: a behavioural 3x3 board drives states/nextCursorGrid,
// expected settled results are queued at stimulus time and popped once the controller goes idle.
module tb_mine_controller;
  localparam int G = 3;
  localparam int N = G * G;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mine_controller_if #(.GRID_SIZE(G), .STATE_SIZE(4), .COUNT_W(8)) bus ();

  mine_controller #(.GRID_SIZE(G), .STATE_SIZE(4), .COUNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [8:0] bomb;
    logic [8:0] reveal;
    logic [8:0] cursor;
    logic [1:0] gs;
    logic [1:0] dir;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Board: cell count of adjacent bombs, 9 for a bomb.
  function automatic logic [35:0] board_states(input logic [8:0] bombs);
    logic [35:0] s;
    int cnt, rr, cc;
    s = '0;
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < G && cc >= 0 && cc < G)
              if (bombs[rr*G + cc]) cnt++;
          end
        end
        s[(r*G + c)*4 +: 4] = bombs[r*G + c] ? 4'd9 : 4'(cnt);
      end
    end
    return s;
  endfunction

  // Board: cursor after one step in direction d, all-zero when it would leave the grid.
  function automatic logic [8:0] board_next(input logic [8:0] cur, input logic [1:0] d);
    logic [8:0] nx;
    int rr, cc;
    nx = '0;
    for (int r = 0; r < G; r++) begin
      for (int c = 0; c < G; c++) begin
        if (cur[r*G + c]) begin
          rr = r;
          cc = c;
          case (d)
            2'b00:   cc = c - 1;
            2'b01:   rr = r + 1;
            2'b10:   cc = c + 1;
            default: rr = r - 1;
          endcase
          if (rr >= 0 && rr < G && cc >= 0 && cc < G) nx[rr*G + cc] = 1'b1;
        end
      end
    end
    return nx;
  endfunction

  assign bus.states         = board_states(bus.bombGrid);
  assign bus.nextCursorGrid = board_next(bus.cursorGrid, bus.dir);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic n, input logic r, input logic m,
                       input logic [1:0] d, input logic [8:0] seed);
    @(negedge clk);
    bus.btnNew    = n;
    bus.btnReveal = r;
    bus.btnMove   = m;
    bus.btnDir    = d;
    bus.bombSeed  = seed;
    tick();
    bus.btnNew    = 1'b0;
    bus.btnReveal = 1'b0;
    bus.btnMove   = 1'b0;
  endtask

  task automatic push_exp(input string tag, input logic [8:0] bomb, input logic [8:0] reveal,
                          input logic [8:0] cursor, input logic [1:0] gs,
                          input logic [1:0] dir, input logic [7:0] cnt);
    exp_t e;
    e.tag = tag; e.bomb = bomb; e.reveal = reveal; e.cursor = cursor;
    e.gs = gs; e.dir = dir; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the controller to settle, then compare against the oldest expectation.
  task automatic drain();
    exp_t e;
    int   waited;
    waited = 0;
    while (bus.busy === 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    e = sb.pop_front();
    check({e.tag, ".settled"}, 32'(bus.busy), 32'd0);
    check({e.tag, ".bomb"},    32'(bus.bombGrid),    32'(e.bomb));
    check({e.tag, ".reveal"},  32'(bus.revealGrid),  32'(e.reveal));
    check({e.tag, ".cursor"},  32'(bus.cursorGrid),  32'(e.cursor));
    check({e.tag, ".state"},   32'(bus.gameState),   32'(e.gs));
    check({e.tag, ".dir"},     32'(bus.dir),         32'(e.dir));
    check({e.tag, ".count"},   32'(bus.revealCount), 32'(e.cnt));
    check({e.tag, ".move"},    32'(bus.move),        32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.btnNew = 1'b0; bus.btnReveal = 1'b0; bus.btnMove = 1'b0;
    bus.btnDir = 2'b00; bus.bombSeed = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    push_exp("reset", 9'h000, 9'h000, 9'h100, 2'b00, 2'b00, 8'd0);
    drain();

    // Reveal and move are ignored while idle.
    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    press(1'b0, 1'b0, 1'b1, 2'b11, 9'h000);
    push_exp("idle_ignore", 9'h000, 9'h000, 9'h100, 2'b00, 2'b00, 8'd0);
    drain();

    // Game 1: bombs on cells 0 and 1.
    press(1'b1, 1'b0, 1'b0, 2'b00, 9'h003);
    check("new1.busy_in_check", 32'(bus.busy), 32'd1);
    push_exp("new1", 9'h003, 9'h000, 9'h100, 2'b01, 2'b00, 8'd0);
    drain();

    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    check("flood.ring0", 32'(bus.revealGrid), 32'h100);
    check("flood.busy",  32'(bus.busy), 32'd1);
    tick();
    check("flood.ring1", 32'(bus.revealGrid), 32'h1B0);
    tick();
    check("flood.ring2", 32'(bus.revealGrid), 32'h1F8);
    push_exp("flood_done", 9'h003, 9'h1F8, 9'h100, 2'b01, 2'b00, 8'd6);
    drain();

    press(1'b0, 1'b0, 1'b1, 2'b11, 9'h000);
    check("move1.move_high", 32'(bus.move), 32'd1);
    check("move1.cursor_not_yet", 32'(bus.cursorGrid), 32'h100);
    tick();
    check("move1.move_low", 32'(bus.move), 32'd0);
    check("move1.cursor", 32'(bus.cursorGrid), 32'h020);
    push_exp("move1", 9'h003, 9'h1F8, 9'h020, 2'b01, 2'b11, 8'd6);
    drain();

    press(1'b0, 1'b0, 1'b1, 2'b11, 9'h000);
    check("move2.move_high", 32'(bus.move), 32'd1);
    tick();
    push_exp("move2", 9'h003, 9'h1F8, 9'h004, 2'b01, 2'b11, 8'd6);
    drain();

    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    push_exp("win", 9'h003, 9'h1FC, 9'h004, 2'b10, 2'b11, 8'd7);
    drain();

    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    press(1'b0, 1'b0, 1'b1, 2'b00, 9'h000);
    push_exp("win_ignore", 9'h003, 9'h1FC, 9'h004, 2'b10, 2'b11, 8'd7);
    drain();

    // Game 2: off-grid move, walk onto a bomb.
    press(1'b1, 1'b0, 1'b0, 2'b00, 9'h003);
    push_exp("new2", 9'h003, 9'h000, 9'h100, 2'b01, 2'b11, 8'd0);
    drain();

    press(1'b0, 1'b0, 1'b1, 2'b10, 9'h000);
    tick();
    push_exp("move_offgrid", 9'h003, 9'h000, 9'h100, 2'b01, 2'b10, 8'd0);
    drain();

    press(1'b0, 1'b0, 1'b1, 2'b00, 9'h000);
    tick();
    push_exp("move_right", 9'h003, 9'h000, 9'h080, 2'b01, 2'b00, 8'd0);
    drain();

    press(1'b0, 1'b0, 1'b1, 2'b11, 9'h000);
    tick();
    press(1'b0, 1'b0, 1'b1, 2'b11, 9'h000);
    tick();
    push_exp("move_down2", 9'h003, 9'h000, 9'h002, 2'b01, 2'b11, 8'd0);
    drain();

    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    push_exp("lose", 9'h003, 9'h003, 9'h002, 2'b11, 2'b11, 8'd2);
    drain();

    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    press(1'b0, 1'b0, 1'b1, 2'b00, 9'h000);
    check("lose_ignore.move", 32'(bus.move), 32'd0);
    push_exp("lose_ignore", 9'h003, 9'h003, 9'h002, 2'b11, 2'b11, 8'd2);
    drain();

    // Reveal wins over a simultaneous move.
    press(1'b1, 1'b0, 1'b0, 2'b00, 9'h003);
    push_exp("new3", 9'h003, 9'h000, 9'h100, 2'b01, 2'b11, 8'd0);
    drain();
    press(1'b0, 1'b1, 1'b1, 2'b00, 9'h000);
    check("both.move", 32'(bus.move), 32'd0);
    check("both.dir", 32'(bus.dir), 32'd3);
    check("both.reveal", 32'(bus.revealGrid), 32'h100);
    push_exp("both_done", 9'h003, 9'h1F8, 9'h100, 2'b01, 2'b11, 8'd6);
    drain();

    // Asynchronous reset mid-flood.
    press(1'b1, 1'b0, 1'b0, 2'b00, 9'h001);
    push_exp("new4", 9'h001, 9'h000, 9'h100, 2'b01, 2'b11, 8'd0);
    drain();
    press(1'b0, 1'b1, 1'b0, 2'b00, 9'h000);
    tick();
    check("midflood.ring1", 32'(bus.revealGrid), 32'h1B0);
    check("midflood.busy", 32'(bus.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_reset.reveal", 32'(bus.revealGrid), 32'h000);
    check("async_reset.bomb",   32'(bus.bombGrid),   32'h000);
    check("async_reset.cursor", 32'(bus.cursorGrid), 32'h100);
    check("async_reset.state",  32'(bus.gameState),  32'd0);
    check("async_reset.busy",   32'(bus.busy),       32'd0);
    check("async_reset.dir",    32'(bus.dir),        32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // All-bomb seed wins straight after the check cycle.
    press(1'b1, 1'b0, 1'b0, 2'b00, 9'h1FF);
    check("allbomb.in_check", 32'(bus.gameState), 32'd1);
    check("allbomb.busy", 32'(bus.busy), 32'd1);
    push_exp("allbomb_win", 9'h1FF, 9'h000, 9'h100, 2'b10, 2'b00, 8'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed=running expected=done");
    $fatal(1);
  end
endmodule
